// File: rtl/ad_regfile_2w.sv
// ad_regfile_2w: dual-write, dual-read integer register file, x0 hardwired to zero.
// Latency: reads are combinational; a write is visible in storage from the edge that commits it.
// Flow control: ready_o is low while the zero-fill sequencer runs, and writes presented then are dropped.
//
// Ports:
//   clk_i, resetn_i            clock, asynchronous active-low reset
//   clear_i / ready_o          zero-fill request / array valid
//   rs1_*, rs2_*               combinational read ports
//   wa_*, wb_*                 write ports A and B (B wins on a same-address collision)
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle committing writes to the reads.
module ad_regfile_2w #(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int REGFILE_DEPTH      = 32
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          clear_i,
  output logic                          ready_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr_i,
  output logic [REG_DATA_WIDTH-1:0]     rs1_data_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [REG_DATA_WIDTH-1:0]     rs2_data_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0] wa_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]     wa_data_i,
  input  logic                          wa_en_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]     wb_data_i,
  input  logic                          wb_en_i
);

  // The counter and the storage index share one width, just wide enough for REGFILE_DEPTH-1.
  localparam int CNT_W = (REGFILE_DEPTH > 1) ? $clog2(REGFILE_DEPTH) : 1;
  // One extra bit so that REGFILE_DEPTH == 2**REGFILE_ADDR_WIDTH stays representable.
  localparam logic [REGFILE_ADDR_WIDTH:0] DEPTH_EXT = (REGFILE_ADDR_WIDTH+1)'(REGFILE_DEPTH);
  localparam logic [CNT_W-1:0]            CNT_LAST  = CNT_W'(REGFILE_DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REG_DATA_WIDTH-1:0] mem [REGFILE_DEPTH];
  logic                      wa_commit, wb_commit;

  // Address selects a real register: not x0 and inside the implemented depth.
  function automatic logic addr_ok(input logic [REGFILE_ADDR_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_EXT);
  endfunction

  assign ready_o   = (state_q == ST_IDLE);
  assign wa_commit = ready_o && wa_en_i && addr_ok(wa_addr_i);
  assign wb_commit = ready_o && wb_en_i && addr_ok(wb_addr_i);

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state. A clear request while clearing restarts the sweep,
  // taking priority over finishing on the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clear_i) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (clear_i) begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage has no reset; the sequencer sweeps it instead. Committed addresses
  // are always in range, so the truncated index is exact. B is written last so
  // it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wa_commit) begin
        mem[wa_addr_i[CNT_W-1:0]] <= wa_data_i;
      end
      if (wb_commit) begin
        mem[wb_addr_i[CNT_W-1:0]] <= wb_data_i;
      end
    end
  end

  // Out-of-range addresses may alias in the truncated index, but their data is masked to zero.
  function automatic logic [REG_DATA_WIDTH-1:0] rd_port(input logic [REGFILE_ADDR_WIDTH-1:0] a);
    logic [REG_DATA_WIDTH-1:0] d;
    d = '0;
    if (ready_o && addr_ok(a)) begin
      d = mem[a[CNT_W-1:0]];
`ifdef REGFILE_BYPASS_EN
      if (wa_commit && (a == wa_addr_i)) begin
        d = wa_data_i;
      end
      if (wb_commit && (a == wb_addr_i)) begin
        d = wb_data_i;
      end
`endif
    end
    return d;
  endfunction

  always_comb begin
    rs1_data_o = rd_port(rs1_addr_i);
    rs2_data_o = rd_port(rs2_addr_i);
  end

endmodule

// File: doc/ad_regfile_2w.md
# ad_regfile_2w

Parametrised dual-write, dual-read integer register file for the decode stage, successor to the single-write regfile. It accepts two independent write ports (for example ALU writeback and load/long-latency writeback) and serves two combinational read ports. Register 0 is hardwired to zero. Because the storage array has no reset, a built-in sequencer zero-fills it after reset or on request and signals completion on `ready_o`.

## Interface
- `REG_DATA_WIDTH`, 32, data width of every register.
- `REGFILE_ADDR_WIDTH`, 5, width of every address port.
- `REGFILE_DEPTH`, 32, number of implemented registers. Range is 2..2^REGFILE_ADDR_WIDTH.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `resetn_i`  in  1  asynchronous, active-low reset.
- `clear_i`  in  1  single-cycle request to zero-fill the whole array.
- `ready_o`  out  1  high when the array is valid; low while clearing.
- `rs1_addr_i`, `rs2_addr_i`  in  REGFILE_ADDR_WIDTH  read addresses.
- `rs1_data_o`, `rs2_data_o`  out  REG_DATA_WIDTH  read data, combinational.
- `wa_addr_i`  in  REGFILE_ADDR_WIDTH  write port A address.
- `wa_data_i`  in  REG_DATA_WIDTH  write port A data.
- `wa_en_i`  in  1  write port A enable.
- `wb_addr_i`  in  REGFILE_ADDR_WIDTH  write port B address.
- `wb_data_i`  in  REG_DATA_WIDTH  write port B data.
- `wb_en_i`  in  1  write port B enable.

## Operation
**Sequencer states: CLEAR, IDLE.**
- While `resetn_i` is low: state = CLEAR, clear counter = 0, `ready_o` = 0.
- CLEAR:
  - Each edge writes 0 to entry `cnt`, then increments `cnt`.
  - At the edge that writes `cnt` = REGFILE_DEPTH-1, the next state is IDLE.
  - `clear_i` asserted during CLEAR restarts `cnt` at 0.
- IDLE:
  - `ready_o` = 1.
  - `clear_i` = 1 moves the block to CLEAR at the next edge with `cnt` = 0.

**Writes**
- A write port commits at the edge only when all of the following hold: state is IDLE, its enable is 1, its address is non-zero, and its address is below REGFILE_DEPTH.
- Writes presented while in CLEAR are dropped.
- Writes presented in the same cycle as `clear_i` in IDLE are committed, then overwritten by the clear.
- If A and B target the same address in the same cycle, B wins.

**Reads**
- Data is forced to 0 when any of these hold: `ready_o` = 0, the address is 0, or the address is at or above REGFILE_DEPTH.
- Otherwise the read returns the stored entry, subject to forwarding (see Configuration).

**Widths:** no arithmetic. Address comparisons use full REGFILE_ADDR_WIDTH bits.

## Timing
- Read latency: 0 cycles (combinational from address to data).
- Write latency: data is visible in storage from the edge that commits it.
- Reset values: `ready_o` = 0, `rs1_data_o` = `rs2_data_o` = 0.
- Clear duration: `ready_o` rises after exactly REGFILE_DEPTH rising edges following reset release, or following the edge that samples `clear_i`.
- `ready_o` falls on the edge that samples `clear_i` in IDLE.
- Reset asserted mid-clear: the sequence aborts and restarts from `cnt` = 0 after release.
- `cnt` is sized to count REGFILE_DEPTH-1 and never wraps past it.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: a read whose address matches a committing write in the same cycle returns that write's data instead of the stored value.
  - B's data takes priority over A's.
  - Only writes that will commit forward; writes to x0, out of range, or during CLEAR do not.
- Undefined: no forwarding. Reads return the stored value, so new data appears the cycle after the write. The writer must stall one cycle to avoid read-after-write hazards.

## Test plan
- **Reset/clear.** Release reset with REGFILE_DEPTH = 32.
  - Expect `ready_o` = 0 for 32 edges, then 1.
  - All 31 non-zero registers read back 0.
- **x0 and range.** Write A to addr 0 with 0xDEADBEEF, and (REGFILE_DEPTH = 16) write B to addr 20 with 0x1234.
  - Expect reads of addr 0 and addr 20 to return 0.
- **Collision.** Same cycle: A writes x5 ← 0x11111111, B writes x5 ← 0x22222222.
  - Expect a later read of x5 to return 0x22222222.
- **Bypass.** Write A x7 ← 0xCAFEF00D while rs1_addr = 7.
  - With `REGFILE_BYPASS_EN` defined: `rs1_data_o` = 0xCAFEF00D in the same cycle.
  - Without it: `rs1_data_o` = 0 in that cycle and 0xCAFEF00D in the next.
- **Clear during operation.** Fill x1..x31 with index values, then pulse `clear_i` together with B write x3 ← 0xAA.
  - Expect `ready_o` low for 32 cycles.
  - Writes issued during the clear are dropped.
  - All registers read 0 afterwards.
- **Reset mid-clear.** Assert `resetn_i` at `cnt` = 10, release it.
  - Expect a full 32-cycle clear before `ready_o` = 1.
